// File: rtl/multi_delay.sv
// Multi-channel programmable modulo counter / delay generator.
// Each channel runs periodic or one-shot and emits a one-cycle terminal pulse.
module multi_delay #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS-1:0]       i_count_enbl,
  input  logic                      i_set_module_enbl,
  input  logic [SEL_W-1:0]          i_chan_sel,
  input  logic [WIDTH-1:0]          i_module,
  input  logic                      i_mode,
  input  logic [CHANNELS-1:0]       i_start,
  output logic [CHANNELS-1:0]       o_cnt,
  output logic [CHANNELS-1:0]       o_busy,
  output logic [CHANNELS*WIDTH-1:0] o_count
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             arm_q, arm_d;
    logic             pls_q, pls_d;
    logic             load;
    logic             step;
    logic             last;

    // Out-of-range selects never match any channel index.
    assign load = i_set_module_enbl &&
                  (i_chan_sel == SEL_W'(k));
    assign step = arm_q && i_count_enbl[k];
    assign last = (cnt_q == mod_q - WIDTH'(1));

    always_comb begin
      mod_d  = mod_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      arm_d  = arm_q;
      pls_d  = 1'b0;
      if (load) begin
        mod_d  = i_module;
        mode_d = i_mode;
        cnt_d  = '0;
        arm_d  = !i_mode && (i_module != '0);
      end else if (step) begin
        if (last) begin
          cnt_d = '0;
          pls_d = 1'b1;
          if (mode_q)
            arm_d = 1'b0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else if (mode_q && !arm_q &&
                   i_start[k] &&
                   (mod_q != '0)) begin
        arm_d = 1'b1;
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        mod_q  <= '0;
        cnt_q  <= '0;
        mode_q <= 1'b0;
        arm_q  <= 1'b0;
        pls_q  <= 1'b0;
      end else begin
        mod_q  <= mod_d;
        cnt_q  <= cnt_d;
        mode_q <= mode_d;
        arm_q  <= arm_d;
        pls_q  <= pls_d;
      end
    end

    assign o_cnt[k]                  = pls_q;
    assign o_busy[k]                 = arm_q;
    assign o_count[k*WIDTH +: WIDTH] = cnt_q;
  end

endmodule

// File: tb/tb_multi_delay.sv
// Scoreboard bench for multi_delay: modulo reference model feeds a queue,
// a monitor pops one expected output set per clock.
module tb_multi_delay;
  localparam int W = 8;
  localparam int C = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [C-1:0]   en = '0;
  logic           ld = 1'b0;
  logic [S-1:0]   sel = '0;
  logic [W-1:0]   modv = '0;
  logic           mode = 1'b0;
  logic [C-1:0]   start = '0;
  logic [C-1:0]   o_cnt;
  logic [C-1:0]   o_busy;
  logic [C*W-1:0] o_count;

  multi_delay #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_count_enbl(en),
    .i_set_module_enbl(ld), .i_chan_sel(sel), .i_module(modv),
    .i_mode(mode), .i_start(start), .o_cnt(o_cnt),
    .o_busy(o_busy), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [C-1:0]   cnt;
    logic [C-1:0]   busy;
    logic [C*W-1:0] count;
  } exp_t;

  exp_t q[$];
  int nchk = 0;
  int nerr = 0;
  int p_cnt[C];
  int b_cnt[C];

  // reference state: plain integers
  int m_mod[C];
  int m_mode[C];
  int m_val[C];
  int m_run[C];

  task automatic check(string name, longint act, longint req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_step();
    exp_t e;
    e = '0;
    for (int k = 0; k < C; k++) begin
      logic p;
      p = 1'b0;
      if (!rst_n) begin
        m_mod[k] = 0; m_mode[k] = 0; m_val[k] = 0; m_run[k] = 0;
      end else if (ld && int'(sel) == k) begin
        m_mod[k]  = int'(modv);
        m_mode[k] = int'(mode);
        m_val[k]  = 0;
        m_run[k]  = (mode == 1'b0 && modv != 0) ? 1 : 0;
      end else if (m_run[k] == 1 && en[k]) begin
        m_val[k] = (m_val[k] + 1) % m_mod[k];
        p = (m_val[k] == 0);
        if (p && m_mode[k] == 1) m_run[k] = 0;
      end else if (m_mode[k] == 1 && m_run[k] == 0 &&
                   start[k] && m_mod[k] != 0) begin
        m_run[k] = 1;
        m_val[k] = 0;
      end
      e.cnt[k]  = p;
      e.busy[k] = (m_run[k] == 1);
      e.count[k*W +: W] = W'(m_val[k]);
    end
    q.push_back(e);
  endtask

  // inputs are stable at a falling edge; one expected set per rising edge
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic clr();
    for (int k = 0; k < C; k++) begin
      p_cnt[k] = 0;
      b_cnt[k] = 0;
    end
  endtask

  task automatic load(int ch, int m, int md);
    ld = 1'b1; sel = S'(ch); modv = W'(m); mode = md[0];
    tick();
    ld = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("o_cnt", longint'(o_cnt), longint'(e.cnt));
      check("o_busy", longint'(o_busy), longint'(e.busy));
      check("o_count", longint'(o_count), longint'(e.count));
      for (int k = 0; k < C; k++) begin
        p_cnt[k] += int'(o_cnt[k]);
        b_cnt[k] += int'(o_busy[k]);
      end
    end
  end

  initial begin
    int guard;
    clr();
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    en = '1;
    for (int i = 0; i < 10; i++) tick();
    check("idle_pulses", p_cnt[0] + p_cnt[1] + p_cnt[2] + p_cnt[3], 0);

    load(0, 3, 0);
    clr();
    for (int i = 0; i < 12; i++) tick();
    check("ch0_m3_pulses", p_cnt[0], 4);
    check("other_silent", p_cnt[1] + p_cnt[2] + p_cnt[3], 0);

    load(2, 5, 1);
    clr();
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    tick(); tick();
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("oneshot_pulses", p_cnt[2], 1);
    check("oneshot_busy", b_cnt[2], 5);

    load(1, 4, 0);
    clr();
    for (int i = 0; i < 16; i++) begin
      en[1] = (i % 2 == 0);
      tick();
    end
    en = '1;
    check("toggle_pulses", p_cnt[1], 2);

    guard = 0;
    while (m_val[0] != 2 && guard < 10) begin
      tick();
      guard++;
    end
    check("reach_cnt2", m_val[0], 2);
    load(0, 2, 0);
    if (2 ** S > C) load(C, 7, 0);
    clr();
    for (int i = 0; i < 8; i++) tick();
    check("reload_m2_pulses", p_cnt[0], 4);

    load(3, 1, 0);
    clr();
    for (int i = 0; i < 6; i++) tick();
    check("m1_pulses", p_cnt[3], 6);

    load(1, 0, 1);
    clr();
    start[1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start[1] = 1'b0;
    check("m0_pulses", p_cnt[1], 0);
    check("m0_busy", b_cnt[1], 0);

    for (int i = 0; i < 400; i++) begin
      en    = C'($urandom);
      start = C'($urandom);
      ld    = ($urandom_range(0, 5) == 0);
      sel   = S'($urandom);
      modv  = W'($urandom_range(0, 7));
      mode  = 1'($urandom);
      tick();
    end
    ld = 1'b0;
    start = '0;
    en = '1;
    load(0, 9, 0);
    tick(); tick();

    rst_n = 1'b0;
    #1;
    check("rst_cnt", longint'(o_cnt), 0);
    check("rst_busy", longint'(o_busy), 0);
    check("rst_count", longint'(o_count), 0);
    tick();
    rst_n = 1'b1;
    clr();
    for (int i = 0; i < 12; i++) tick();
    check("post_rst_pulses", p_cnt[0] + p_cnt[1] + p_cnt[2] + p_cnt[3], 0);

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
